double_dabble_bcd2bin: RTL and testbench

- Sequential BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from every BCD digit ≥ 8.
- Inverse of the team's binary-to-BCD converter.
- Sits beside the multiplier display/IO path to turn packed BCD operands (e.g. keypad entry) into binary for the booth multiplier.
- Digit-serial correction, one digit per cycle, to keep area small.

---
 rtl/double_dabble_bin2bcd_pkg.sv | 37 +++
 rtl/double_dabble_bcd2bin_bcd_digit_sub3.sv | 9 +
 rtl/double_dabble_bcd2bin.sv | 140 ++++++++++++++
 tb/tb_double_dabble_bcd2bin.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/double_dabble_bin2bcd_pkg.sv
// Shared types and width helpers for the binary<->BCD converter pair.
package double_dabble_bin2bcd_pkg;

  typedef enum logic [2:0] {
    IDLE_S              = 3'd0,
    SHIFT_S             = 3'd1,
    CHECK_SHIFT_INDEX_S = 3'd2,
    SUB_S               = 3'd3,
    CHECK_DIGIT_INDEX_S = 3'd4,
    BCD_DONE_S          = 3'd5
  } double_dabble_bcd2bin_state_e;

  // Smallest width able to hold 10**num_digits distinct values.
  function automatic int get_bin_width(input int num_digits);
    longint unsigned p;
    int w;
    p = 1;
    for (int i = 0; i < num_digits; i++) p = p * 10;
    w = 0;
    while ((64'd1 << w) < p) w++;
    return w;
  endfunction

  // Decimal digits needed to print 2**bin_width-1.
  function automatic int get_num_digits(input int bin_width);
    longint unsigned maxv;
    int n;
    maxv = (64'd1 << bin_width) - 64'd1;
    n    = 1;
    while (maxv >= 10) begin
      maxv = maxv / 10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/double_dabble_bcd2bin_bcd_digit_sub3.sv
// One-digit correction for reverse double dabble: a shifted-in half-ten shows up as 8, must read as 5.
module bcd_digit_sub3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/double_dabble_bcd2bin.sv
// Packed BCD to binary via reverse double dabble, correcting one digit per cycle.
module double_dabble_bcd2bin
  import double_dabble_bin2bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_i,
  input  logic [4*NUM_DIGITS-1:0]               bcd_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [get_bin_width(NUM_DIGITS)-1:0]  bin_o,
  output logic                                  err_o
);

  localparam int BIN_WIDTH = get_bin_width(NUM_DIGITS);
  localparam int BCD_W     = 4 * NUM_DIGITS;
  localparam int CNT_W     = $clog2(BIN_WIDTH + 1);
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  double_dabble_bcd2bin_state_e state_q, state_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [CNT_W-1:0]     shift_cnt_q, shift_cnt_d;
  logic [IDX_W-1:0]     digit_idx_q, digit_idx_d;
  logic                 done_q, done_d;
  logic [BIN_WIDTH-1:0] bin_out_q, bin_out_d;
  logic                 err_q, err_d;

  logic [NUM_DIGITS-1:0] digit_bad;
  logic [3:0]            digit_sel;
  logic [3:0]            digit_fix;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_chk
      assign digit_bad[gi] = (bcd_i[4*gi +: 4] > 4'd9);
    end
  endgenerate

  // Single shared corrector; the digit under correction is muxed in by index.
  always_comb begin
    digit_sel = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == IDX_W'(i)) digit_sel = bcd_q[4*i +: 4];
    end
  end

  bcd_digit_sub3 u_sub3 (
    .digit_i (digit_sel),
    .digit_o (digit_fix)
  );

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    shift_cnt_d = shift_cnt_q;
    digit_idx_d = digit_idx_q;
    done_d      = 1'b0;
    bin_out_d   = bin_out_q;
    err_d       = err_q;
    case (state_q)
      IDLE_S: begin
        if (start_i) begin
          bcd_d       = bcd_i;
          bin_d       = '0;
          shift_cnt_d = '0;
          err_d       = |digit_bad;
          state_d     = SHIFT_S;
        end
      end
      SHIFT_S: begin
        {bcd_d, bin_d} = {bcd_q, bin_q} >> 1;
        shift_cnt_d    = shift_cnt_q + 1'b1;
        state_d        = CHECK_SHIFT_INDEX_S;
      end
      CHECK_SHIFT_INDEX_S: begin
        if (shift_cnt_q == CNT_W'(BIN_WIDTH)) begin
          state_d = BCD_DONE_S;
        end else begin
          digit_idx_d = '0;
          state_d     = SUB_S;
        end
      end
      SUB_S: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (digit_idx_q == IDX_W'(i)) bcd_d[4*i +: 4] = digit_fix;
        end
        state_d = CHECK_DIGIT_INDEX_S;
      end
      CHECK_DIGIT_INDEX_S: begin
        if (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
          state_d = SHIFT_S;
        end else begin
          digit_idx_d = digit_idx_q + 1'b1;
          state_d     = SUB_S;
        end
      end
      BCD_DONE_S: begin
        done_d    = 1'b1;
        bin_out_d = err_q ? '0 : bin_q;
        state_d   = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE_S;
      bcd_q       <= '0;
      bin_q       <= '0;
      shift_cnt_q <= '0;
      digit_idx_q <= '0;
      done_q      <= 1'b0;
      bin_out_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      shift_cnt_q <= shift_cnt_d;
      digit_idx_q <= digit_idx_d;
      done_q      <= done_d;
      bin_out_q   <= bin_out_d;
      err_q       <= err_d;
    end
  end

  assign busy_o = (state_q != IDLE_S);
  assign done_o = done_q;
  assign bin_o  = bin_out_q;
  assign err_o  = err_q;

  // A valid operand must have been fully drained out of the BCD side.
  a_bcd_drained: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == BCD_DONE_S && !err_q) |-> (bcd_q == '0));

endmodule

// File: tb/tb_double_dabble_bcd2bin.sv
// Bench for the BCD-to-binary converter: 3-digit and 1-digit builds side by side.
module tb_double_dabble_bcd2bin;

  localparam int L3 = 75;
  localparam int L1 = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start3, start1;
  logic [11:0] bcd3;
  logic [3:0]  bcd1;
  logic        busy3, done3, err3;
  logic        busy1, done1, err1;
  logic [9:0]  bin3;
  logic [3:0]  bin1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  double_dabble_bcd2bin #(.NUM_DIGITS(3)) dut3 (
    .clk (clk), .rst_n (rst_n), .start_i (start3), .bcd_i (bcd3),
    .busy_o (busy3), .done_o (done3), .bin_o (bin3), .err_o (err3)
  );

  double_dabble_bcd2bin #(.NUM_DIGITS(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .start_i (start1), .bcd_i (bcd1),
    .busy_o (busy1), .done_o (done1), .bin_o (bin1), .err_o (err1)
  );

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal value of the digits, or 0 with err if any digit is not decimal.
  task automatic ref_model(input logic [11:0] bcd, output logic [9:0] eb, output logic ee);
    int v;
    int d;
    v  = 0;
    ee = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      d = int'(bcd[4*k +: 4]);
      if (d > 9) ee = 1'b1;
      v = v * 10 + d;
    end
    eb = ee ? 10'd0 : 10'(v);
  endtask

  // Caller is #1 after an edge; start is accepted on the next edge.
  task automatic conv3(input logic [11:0] bcd, input logic [9:0] eb, input logic ee, input int poke_at);
    int bad_cyc;
    bad_cyc = -1;
    start3  = 1'b1;
    bcd3    = bcd;
    @(posedge clk); #1;
    start3  = 1'b0;
    bcd3    = 12'h999;
    for (int i = 0; i < L3; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if ((busy3 !== 1'b1 || done3 !== 1'b0) && bad_cyc < 0) bad_cyc = i;
      start3 = (i == poke_at);
    end
    start3 = 1'b0;
    @(posedge clk); #1;
    check("busy_window", 32'(bad_cyc), 32'hFFFF_FFFF);
    check("done_at_L", {31'd0, done3}, 32'd1);
    check("busy_at_L", {31'd0, busy3}, 32'd0);
    check("bin", {22'd0, bin3}, {22'd0, eb});
    check("err", {31'd0, err3}, {31'd0, ee});
    $display("conv3 bcd=%h bin=%0d err=%0b exp_bin=%0d exp_err=%0b", bcd, bin3, err3, eb, ee);
  endtask

  task automatic conv1(input logic [3:0] bcd, input logic [3:0] eb, input logic ee);
    int bad_cyc;
    bad_cyc = -1;
    start1  = 1'b1;
    bcd1    = bcd;
    @(posedge clk); #1;
    start1  = 1'b0;
    bcd1    = 4'h0;
    for (int i = 0; i < L1; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if ((busy1 !== 1'b1 || done1 !== 1'b0) && bad_cyc < 0) bad_cyc = i;
    end
    @(posedge clk); #1;
    check("n1_busy_window", 32'(bad_cyc), 32'hFFFF_FFFF);
    check("n1_done_at_L", {31'd0, done1}, 32'd1);
    check("n1_bin", {28'd0, bin1}, {28'd0, eb});
    check("n1_err", {31'd0, err1}, {31'd0, ee});
    $display("conv1 bcd=%h bin=%0d err=%0b exp_bin=%0d exp_err=%0b", bcd, bin1, err1, eb, ee);
  endtask

  initial begin
    logic [11:0] rb;
    logic [9:0]  eb;
    logic        ee;
    logic [3:0]  dig;
    int          flag;

    tbl[0] = '{12'h000, 10'd0,   1'b0};
    tbl[1] = '{12'h999, 10'd999, 1'b0};
    tbl[2] = '{12'h009, 10'd9,   1'b0};
    tbl[3] = '{12'h090, 10'd90,  1'b0};
    tbl[4] = '{12'h900, 10'd900, 1'b0};
    tbl[5] = '{12'hF00, 10'd0,   1'b1};
    tbl[6] = '{12'h512, 10'd512, 1'b0};
    tbl[7] = '{12'h1A5, 10'd0,   1'b1};
    tbl[8] = '{12'h042, 10'd42,  1'b0};

    rst_n  = 1'b0;
    start3 = 1'b0;
    start1 = 1'b0;
    bcd3   = '0;
    bcd1   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy3}, 32'd0);
    check("rst_done", {31'd0, done3}, 32'd0);
    check("rst_bin", {22'd0, bin3}, 32'd0);
    check("rst_err", {31'd0, err3}, 32'd0);
    check("rst_n1_busy", {31'd0, busy1}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 9; t++) begin
      conv3(tbl[t].bcd, tbl[t].bin, tbl[t].err, -1);
      @(posedge clk); #1;
      check("done_pulse_width", {31'd0, done3}, 32'd0);
    end

    // Stray start mid-run is ignored, then a back-to-back start in the done cycle.
    conv3(12'h255, 10'd255, 1'b0, 20);
    conv3(12'h100, 10'd100, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    check("bin_held", {22'd0, bin3}, 32'd100);
    check("done_idle", {31'd0, done3}, 32'd0);

    // Asynchronous abort mid-conversion.
    start3 = 1'b1;
    bcd3   = 12'h777;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy3}, 32'd0);
    check("abort_done", {31'd0, done3}, 32'd0);
    check("abort_bin", {22'd0, bin3}, 32'd0);
    check("abort_err", {31'd0, err3}, 32'd0);
    $display("abort during 777: busy=%0b done=%0b bin=%0d", busy3, done3, bin3);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    flag  = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done3 !== 1'b0 || busy3 !== 1'b0) flag = 1;
    end
    check("no_done_after_abort", 32'(flag), 32'd0);
    conv3(12'h777, 10'd777, 1'b0, -1);

    for (int r = 0; r < 16; r++) begin
      rb = '0;
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 7) == 0) dig = 4'($urandom_range(10, 15));
        else                           dig = 4'($urandom_range(0, 9));
        rb[4*k +: 4] = dig;
      end
      ref_model(rb, eb, ee);
      conv3(rb, eb, ee, -1);
    end

    for (int v = 0; v < 16; v++) begin
      conv1(4'(v), (v <= 9) ? 4'(v) : 4'd0, (v > 9));
    end
    @(posedge clk); #1;
    check("n1_done_pulse_width", {31'd0, done1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
